ram_burst_reader: RTL and testbench

Sits directly upstream of the single-port RAM and acts as its read master. On a start command it issues a burst of sequential reads from a base address for a given length. Returned words are captured into a small internal FIFO and presented to a downstream consumer over a valid/ready stream. Read issue is credit-limited, so the FIFO never overflows, and a stalled consumer throttles RAM reads.

---
 rtl/ram_burst_reader_pkg.sv | 25 ++
 rtl/ram_burst_reader_sync_fifo.sv | 60 ++++++
 rtl/ram_burst_reader.sv | 161 ++++++++++++++++
 tb/tb_ram_burst_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM encoding and RAM-derived widths.
package ram_burst_reader_pkg;

    // Geometry of the RAM instance this reader is paired with.
    localparam int unsigned RAM_DATA_WIDTH    = 32;
    localparam int unsigned RAM_DEPTH_DEFAULT = 512;

    // Address width for a RAM of the given depth (at least one bit).
    function automatic int unsigned addr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One write-enable bit per byte lane, rounding up a partial lane.
    function automatic int unsigned wren_width(int unsigned data_width);
        return (data_width + 7) / 8;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/ram_burst_reader_sync_fifo.sv
// Small synchronous FIFO with simultaneous push/pop, including push while full
// when a pop frees the slot in the same cycle.
module ram_burst_reader_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    // Accept/pop qualification and pointer/count next state.
    always_comb begin
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
    end

    // Storage, pointers and occupancy with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master for a single-port RAM. Issues sequential reads from a base
// address, buffers returned words in a small FIFO and streams them out over
// valid/ready. Issue is credit-limited against FIFO space so it never overflows.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned RAM_DEPTH  = RAM_DEPTH_DEFAULT,
    parameter int unsigned LEN_WIDTH  = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ADDR_WIDTH = addr_width(RAM_DEPTH),
    localparam int unsigned WREN_WIDTH = wren_width(DATA_WIDTH)
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] baseAddrIn,
    input  logic [LEN_WIDTH-1:0]  lenIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic [ADDR_WIDTH-1:0] ramAddrOut,
    output logic                  ramRdEnOut,
    output logic [WREN_WIDTH-1:0] ramWrEnOut,
    input  logic [DATA_WIDTH-1:0] ramRdDataIn,
    input  logic                  ramRdAckIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    input  logic                  readyIn
);

    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  accepted_q, accepted_d;
    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_rd_en_q, ram_rd_en_d;

    logic                  issue_now;
    logic                  ack_take;
    logic [CNT_WIDTH:0]    credit_used;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [DATA_WIDTH-1:0] fifo_data;

    ram_burst_reader_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clkIn),
        .rst_i   (rstIn),
        .push_i  (fifo_push),
        .data_i  (ramRdDataIn),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Words already buffered plus words requested but not yet returned.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_q};

    // Acks arriving while idle belong to a burst aborted by reset; drop them.
    assign ack_take  = ramRdAckIn && (state_q != StIdle);
    assign fifo_push = ack_take && (!fifo_full || fifo_pop);
    assign fifo_pop  = !fifo_empty && readyIn;

    // Next-state for the FSM, issue/credit counters and the registered RAM port.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        issued_d    = issued_q;
        accepted_d  = accepted_q;
        inflight_d  = inflight_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_en_d = 1'b0;

        issue_now = (state_q == StRead) && (issued_q < len_q)
                    && (credit_used < (CNT_WIDTH + 1)'(FIFO_DEPTH));

        if (issue_now) begin
            ram_rd_en_d = 1'b1;
            // Power-of-two RAM: truncation gives the wrap past the top address.
            ram_addr_d  = base_q + ADDR_WIDTH'(issued_q);
            issued_d    = issued_q + LEN_WIDTH'(1);
        end

        inflight_d = inflight_q + CNT_WIDTH'(issue_now) - CNT_WIDTH'(ack_take);

        if (fifo_pop) begin
            accepted_d = accepted_q + LEN_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (startIn) begin
                    base_d     = baseAddrIn;
                    len_d      = lenIn;
                    issued_d   = '0;
                    accepted_d = '0;
                    inflight_d = '0;
                    state_d    = (lenIn == '0) ? StDone : StRead;
                end
            end
            StRead, StDrain: begin
                // Look at the post-pop count so done lands the cycle after the last pop.
                if ((issued_q == len_q) && (accepted_d == len_q)) begin
                    state_d = StDone;
                end else if (issued_q == len_q) begin
                    state_d = StDrain;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= '0;
            ram_addr_q  <= '0;
            ram_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            accepted_q  <= accepted_d;
            inflight_q  <= inflight_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_en_q <= ram_rd_en_d;
        end
    end

    assign busyOut    = (state_q != StIdle);
    assign doneOut    = (state_q == StDone);
    assign ramAddrOut = ram_addr_q;
    assign ramRdEnOut = ram_rd_en_q;
    assign ramWrEnOut = '0;
    assign dataOut    = fifo_data;
    assign validOut   = !fifo_empty;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: behavioural RAM, table of bursts with randomized
// consumer backpressure, plus hand-written reset and random-burst sequences.
module tb_ram_burst_reader;
    import ram_burst_reader_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned LW    = 10;
    localparam int unsigned FD    = 4;
    localparam int unsigned AW    = addr_width(DEPTH);
    localparam int unsigned WW    = wren_width(DW);
    localparam int          BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic          rd_en;
    logic [WW-1:0] wren;
    logic [DW-1:0] ram_data = '0;
    logic          ram_ack = 1'b0;
    logic [DW-1:0] dout;
    logic          valid;
    logic          ready;

    int n_pass  = 0;
    int n_total = 0;

    ram_burst_reader #(
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (DEPTH),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clkIn       (clk),
        .rstIn       (rst),
        .startIn     (start),
        .baseAddrIn  (base),
        .lenIn       (len),
        .busyOut     (busy),
        .doneOut     (done),
        .ramAddrOut  (addr),
        .ramRdEnOut  (rd_en),
        .ramWrEnOut  (wren),
        .ramRdDataIn (ram_data),
        .ramRdAckIn  (ram_ack),
        .dataOut     (dout),
        .validOut    (valid),
        .readyIn     (ready)
    );

    always #5 clk = ~clk;

    // RAM contents: each word holds its own address.
    function automatic logic [DW-1:0] ram_word(int unsigned a);
        return DW'(a);
    endfunction

    // One-cycle read latency RAM.
    always @(posedge clk) begin
        ram_ack  <= rd_en;
        ram_data <= rd_en ? ram_word(int'(addr)) : '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        int b;
        int l;
        int pct;       // chance in percent that the consumer is ready
        int hold;      // cycles with ready forced low after start
        bit glitch;    // pulse start again while busy
        int exp_done;  // expected done cycle after start edge, -1 = unchecked
        int exp_last;  // expected final RAM address, -1 = unchecked
    } vec_t;

    // Run one burst; model: word i comes from address (b+i) mod DEPTH, in order.
    task automatic run_burst(input string tag, input int b, input int l, input int pct,
                             input int hold, input bit glitch, input int exp_done,
                             input int exp_last);
        int n_en = 0;
        int n_pop = 0;
        int done_at = -1;
        int first_en = -1;
        int first_valid = -1;
        bit have_held = 1'b0;
        logic [DW-1:0] held = '0;

        @(negedge clk);
        start = 1'b1;
        base  = AW'(b);
        len   = LW'(l);
        ready = 1'b1;
        for (int s = 0; s < BUDGET && done_at < 0; s++) begin
            @(negedge clk);
            if (s == 0) start = 1'b0;
            if (glitch && s == 2) begin
                start = 1'b1;
                base  = AW'(32'h1AA);
                len   = LW'(7);
            end else if (glitch && s == 3) begin
                start = 1'b0;
            end
            check({tag, " busy"}, 64'(busy), 64'd1);
            if (rd_en) begin
                check({tag, " addr"}, 64'(addr), 64'((b + n_en) % DEPTH));
                if (first_en < 0) first_en = s;
                n_en++;
            end
            check({tag, " credit"}, 64'((n_en - n_pop) <= int'(FD)), 64'd1);
            if (done) done_at = s;
            if (hold > 0 && s == hold - 1) check({tag, " issued under stall"}, 64'(n_en), 64'(FD));
            if (s < hold) ready = 1'b0;
            else ready = ($urandom_range(99) < pct);
            if (valid && s < hold) begin
                if (!have_held) begin
                    held = dout;
                    have_held = 1'b1;
                end else begin
                    check({tag, " stalled data"}, 64'(dout), 64'(held));
                end
            end
            if (valid && first_valid < 0) first_valid = s;
            if (valid && ready) begin
                check({tag, " data"}, 64'(dout), 64'(ram_word((b + n_pop) % DEPTH)));
                n_pop++;
            end
        end
        check({tag, " done seen"}, 64'(done_at >= 0), 64'd1);
        check({tag, " reads"}, 64'(n_en), 64'(l));
        check({tag, " words"}, 64'(n_pop), 64'(l));
        if (exp_done >= 0) begin
            check({tag, " done cycle"}, 64'(done_at), 64'(exp_done));
            if (l > 0) begin
                check({tag, " first read cycle"}, 64'(first_en), 64'd1);
                check({tag, " first valid cycle"}, 64'(first_valid), 64'd3);
            end
        end
        if (exp_last >= 0) check({tag, " last addr"}, 64'(addr), 64'(exp_last));
        @(negedge clk);
        ready = 1'b1;
        check({tag, " busy after done"}, 64'(busy), 64'd0);
        check({tag, " single done"}, 64'(done), 64'd0);
        check({tag, " no read after done"}, 64'(rd_en), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " rd_en"}, 64'(rd_en), 64'd0);
        check({tag, " addr"}, 64'(addr), 64'd0);
        check({tag, " valid"}, 64'(valid), 64'd0);
        check({tag, " data"}, 64'(dout), 64'd0);
        check({tag, " wren"}, 64'(wren), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   n_pop;
        bit   early_done;

        vecs[0] = '{32'h010, 4,   100, 0,  1'b0, 7,   32'h013};
        vecs[1] = '{32'h1FE, 4,   100, 0,  1'b0, 7,   32'h001};
        vecs[2] = '{32'h0AB, 1,   100, 0,  1'b0, 4,   32'h0AB};
        vecs[3] = '{32'h040, 8,   100, 10, 1'b0, -1,  32'h047};
        vecs[4] = '{32'h100, 0,   100, 0,  1'b0, 0,   -1};
        vecs[5] = '{32'h020, 3,   100, 0,  1'b1, 6,   32'h022};
        vecs[6] = '{32'h1F0, 20,  50,  0,  1'b0, -1,  32'h003};
        vecs[7] = '{32'h123, 100, 40,  0,  1'b0, -1,  32'h186};
        vecs[8] = '{32'h1C0, 100, 100, 0,  1'b0, 103, 32'h023};

        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        for (int i = 0; i < 9; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].b, vecs[i].l, vecs[i].pct,
                      vecs[i].hold, vecs[i].glitch, vecs[i].exp_done, vecs[i].exp_last);
        end

        // Reset in the middle of a burst, after two words were taken.
        @(negedge clk);
        start = 1'b1;
        base  = AW'(32'h080);
        len   = LW'(10);
        ready = 1'b1;
        n_pop = 0;
        early_done = 1'b0;
        for (int s = 0; s < 50 && n_pop < 2; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) early_done = 1'b1;
            if (valid && ready) n_pop++;
        end
        check("midrst words before reset", 64'(n_pop), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (done || valid || rd_en || busy) early_done = 1'b1;
        end
        check("midrst quiet after abort", 64'(early_done), 64'd0);
        run_burst("postrst", 32'h0C0, 5, 100, 0, 1'b0, 8, 32'h0C4);

        // Random bursts against the address-order model.
        for (int r = 0; r < 4; r++) begin
            int b;
            int l;
            b = int'($urandom_range(DEPTH - 1));
            l = int'($urandom_range(40, 1));
            run_burst($sformatf("rand%0d", r), b, l, int'($urandom_range(100, 20)), 0, 1'b0,
                      -1, (b + l - 1) % DEPTH);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
